calc_sequencer: RTL
===================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port clr, input, 1 bit: synchronous sequence abort.
REQ-004 SHALL have port in_data, input, 10 bits: two's-complement operand, range -512..511.
REQ-005 SHALL have port in_op, input, 1 bit: 0 = add operand, 1 = subtract operand.
REQ-006 SHALL have port in_valid, input, 1 bit: operand offered.
REQ-007 SHALL have port in_ready, output, 1 bit: operand can be accepted.
REQ-008 SHALL have port out_data, output, 11 bits: bits [9:0] are the result, bit [10] is the overflow flag (matches the 11-bit bus standard).
REQ-009 SHALL have port out_valid, output, 1 bit: result presented.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream consumes result.
REQ-011 SHALL have port count, output, 2 bits: operands accepted in the current sequence, 0..3.

Function
REQ-012 SHALL implement states IDLE, ACC1, ACC2 and DONE.
REQ-013 SHALL accept an operand on any rising edge where in_valid and in_ready are both 1 (transfer).
REQ-014 SHALL drive in_ready = 1 in IDLE, ACC1 and ACC2, and in_ready = 0 in DONE.
REQ-015 SHALL use a 12-bit signed accumulator, so that all three-operand sums are exact.
REQ-016 SHALL set acc = 0 + in_data (in_op = 0) or acc = 0 - in_data (in_op = 1) on a transfer in IDLE, then move to ACC1.
REQ-017 SHALL set acc = acc ± in_data (sign-extended) on a transfer in ACC1, then move to ACC2.
REQ-018 SHALL register the final result on a transfer in ACC2, move to DONE, and assert out_valid on the next cycle (1-cycle latency from the third transfer).
REQ-019 SHALL set overflow = 1 when the final 12-bit sum lies outside -512..511; otherwise overflow = 0.
REQ-020 SHALL set out_data[9:0] = acc[9:0] (wrapped) when overflow is 1 and CALC_SATURATE_EN is undefined.
REQ-021 SHALL drive out_valid = 1 only in DONE, and hold out_data stable while out_valid = 1 and out_ready = 0.
REQ-022 SHALL deassert out_valid on an edge in DONE where out_ready = 1, return to IDLE, and clear count to 0.
REQ-023 SHALL keep state, acc and count unchanged on cycles with no transfer in IDLE, ACC1 and ACC2.
REQ-024 SHALL give clr priority over all other inputs: on clr = 1 go to IDLE, set acc = 0, count = 0 and out_valid = 0, and ignore any simultaneous transfer or out_ready.
REQ-025 SHALL increment count on each transfer and hold it at 3 in DONE.
REQ-026 SHALL hold out_data at its last registered value when out_valid = 0 (don't-care to consumers).
REQ-027 SHALL treat -512 - (-512) as exact: the 12-bit sum is 0 with no overflow.

Reset
REQ-028 SHALL, while rst_n = 0 and regardless of clk, force state = IDLE, acc = 0, count = 0, out_valid = 0 and out_data = 11'h000.
REQ-029 SHALL discard any partial sequence when reset is asserted mid-operation.
REQ-030 SHALL drive in_ready = 1 in the first cycle after rst_n deasserts.

Configuration
REQ-031 SHALL support macro CALC_SATURATE_EN: when defined and overflow is 1, out_data[9:0] = 10'h1FF (511) for a positive sum or 10'h200 (-512) for a negative sum, with out_data[10] = 1.
REQ-032 SHALL produce wrapped results per REQ-020 when CALC_SATURATE_EN is undefined; out_data[10], latency and handshake are identical in both builds.

Verification
REQ-033 Bench SHALL cover: +100, +200, +50 (all in_op = 0) -> out_data = 11'h15E (350), overflow 0, out_valid 1 cycle after the third transfer.
REQ-034 Bench SHALL cover: +511, +511, +1 -> sum 1023; default build out_data = 11'h7FF (wrapped 10'h3FF, flag 1); CALC_SATURATE_EN build out_data = 11'h5FF.
REQ-035 Bench SHALL cover: -512, -1 (in_op = 0), +10 (in_op = 1) -> sum -523; default out_data = 11'h5F5; saturate build out_data = 11'h600.
REQ-036 Bench SHALL cover: a result held with out_ready = 0 for 5 cycles -> out_data stable, in_ready = 0, in_valid pulses ignored; out_ready = 1 -> IDLE next cycle, count = 0.
REQ-037 Bench SHALL cover: clr asserted after 2 transfers, concurrent with in_valid -> IDLE, count = 0, operand dropped; next sequence 5, 6 (in_op = 1), 7 -> out_data = 11'h006.
REQ-038 Bench SHALL cover: rst_n pulsed low between clk edges in ACC2 -> outputs reset immediately, out_valid never asserts for the aborted sequence.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer: three-operand signed add/subtract sequencer with overflow flag
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous sequence abort, overrides every other input
//   in_data    10-bit two's-complement operand
//   in_op      0 = add operand, 1 = subtract operand
//   in_valid   operand offered
//   in_ready   operand can be accepted (low only while a result is held)
//   out_data   [9:0] result, [10] overflow flag
//   out_valid  result presented
//   out_ready  downstream consumes result
//   count      operands accepted in the current sequence
// Build option: define CALC_SATURATE_EN to clamp overflowing results to 511 / -512
// instead of wrapping them to 10 bits.
module calc_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [9:0]  in_data,
  input  logic        in_op,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [10:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  count
);
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;
  state_t             state_q;
  logic signed [11:0] acc_q, opnd, sum_d;
  logic [10:0]        out_data_q;
  logic               out_valid_q, xfer, ovf;
  logic [1:0]         count_q;
  logic [9:0]         res_d;
  assign in_ready  = state_q != DONE;
  assign xfer      = in_valid && in_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  // The first operand starts from zero, so a stale accumulator never leaks in.
  always_comb begin
    opnd  = {{2{in_data[9]}}, in_data};
    sum_d = (state_q == IDLE ? 12'sd0 : acc_q) + (in_op ? -opnd : opnd);
    ovf   = sum_d > 12'sd511 || sum_d < -12'sd512;
`ifdef CALC_SATURATE_EN
    res_d = ovf ? (sum_d[11] ? 10'h200 : 10'h1FF) : sum_d[9:0];
`else
    res_d = sum_d[9:0];
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (clr) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (state_q == DONE) begin
      if (out_ready) begin
        state_q     <= IDLE;
        count_q     <= '0;
        out_valid_q <= 1'b0;
      end
    end else if (xfer) begin
      acc_q   <= sum_d;
      count_q <= count_q + 2'd1;
      state_q <= state_t'(state_q + 2'd1);
      if (state_q == ACC2) begin
        out_data_q  <= {ovf, res_d};
        out_valid_q <= 1'b1;
      end
    end
  end
endmodule
